// File: rtl/htif_tohost_port.sv
// Core-side tohost/fromhost endpoint: snoops data-memory requests, raises the
// one-cycle tohost notification, then stalls for a host reply or halts on an exit code.
module htif_tohost_port #(
    parameter int unsigned     AW            = 32,
    parameter int unsigned     DW            = 64,
    parameter logic [AW-1:0]   TOHOST_ADDR   = AW'(32'h0000_1000),
    parameter logic [AW-1:0]   FROMHOST_ADDR = AW'(32'h0000_1040)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          tohost_we,
    output logic [31:0]   tohost,
    input  logic          fromhost_we,
    input  logic [31:0]   fromhost,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NOTIFY = 2'd1,
        WAIT   = 2'd2,
        HALT   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     tohost_q, tohost_d;
    logic [31:0]     fromhost_q, fromhost_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic            accept;
    logic            hit_tohost;
    logic            hit_fromhost;

    // Doubleword granularity: byte offset bits and the upper data word play no part.
    logic            unused_bits;
    assign unused_bits = ^{req_addr[2:0], req_wdata[DW-1:32]};

    assign req_ready    = (state_q == IDLE);
    assign accept       = req_valid && req_ready;
    assign hit_tohost   = (req_addr[AW-1:3] == TOHOST_ADDR[AW-1:3]);
    assign hit_fromhost = (req_addr[AW-1:3] == FROMHOST_ADDR[AW-1:3]);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        tohost_d    = tohost_q;
        fromhost_d  = fromhost_q;
        rsp_valid_d = accept;
        rsp_rdata_d = '0;

        if (accept) begin
            if (req_we) begin
                if (hit_tohost) begin
                    tohost_d = req_wdata[31:0];
                    if (req_wdata[31:0] != 32'd0) begin
                        state_d = NOTIFY;
                    end
                end else if (hit_fromhost) begin
                    fromhost_d = req_wdata[31:0];
                end
            end else if (hit_tohost) begin
                rsp_rdata_d = {{(DW-32){1'b0}}, tohost_q};
            end else if (hit_fromhost) begin
                rsp_rdata_d = {{(DW-32){1'b0}}, fromhost_q};
            end
        end

        // Placed after the core store so a simultaneous host reply wins.
        if (fromhost_we && (state_q != HALT)) begin
            fromhost_d = fromhost;
        end

        unique case (state_q)
            NOTIFY:  state_d = tohost_q[0] ? HALT : WAIT;
            WAIT:    if (fromhost_we) state_d = IDLE;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            tohost_q    <= '0;
            fromhost_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign tohost_we = (state_q == NOTIFY);
    assign tohost    = tohost_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_htif_tohost_port.sv
// Directed bench for htif_tohost_port: notification, host reply, exit halt,
// reply collision and asynchronous reset in the wait state.
module tb_htif_tohost_port;

    logic        CLK;
    logic        RSTn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        tohost_we;
    logic [31:0] tohost;
    logic        fromhost_we;
    logic [31:0] fromhost;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    htif_tohost_port dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .tohost_we   (tohost_we),
        .tohost      (tohost),
        .fromhost_we (fromhost_we),
        .fromhost    (fromhost),
        .halted      (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for a single edge; on return the bench sits in cycle N+1.
    task automatic send(input logic we, input logic [31:0] addr, input logic [63:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Status vector: {req_ready, tohost_we, rsp_valid, halted}
    function automatic logic [3:0] status();
        return {req_ready, tohost_we, rsp_valid, halted};
    endfunction

    initial begin
        RSTn        = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        fromhost_we = 1'b0;
        fromhost    = '0;
        repeat (3) tick();
        RSTn = 1'b1;

        // Idle after reset: ready, nothing else.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_status", 64'(status()), 64'(4'b1000));
            check("idle_tohost", 64'(tohost), 64'd0);
        end

        // Non-exit store: notification then wait; upper data word ignored.
        send(1'b1, 32'h0000_1000, 64'hDEAD_BEEF_8000_0010);
        check("notify_status", 64'(status()), 64'(4'b0110));
        check("notify_rdata", rsp_rdata, 64'd0);
        check("notify_tohost", 64'(tohost), 64'h8000_0010);
        tick();
        check("wait_status0", 64'(status()), 64'(4'b0000));
        tick();
        check("wait_status1", 64'(status()), 64'(4'b0000));
        fromhost_we = 1'b1;
        fromhost    = 32'h5;
        tick();
        fromhost_we = 1'b0;
        fromhost    = '0;
        check("reply_ready", 64'(status()), 64'(4'b1000));
        send(1'b0, 32'h0000_1040, 64'd0);
        check("ld_fromhost_v", 64'(rsp_valid), 64'd1);
        check("ld_fromhost_d", rsp_rdata, 64'h5);
        send(1'b0, 32'h0000_1004, 64'd0);
        check("ld_tohost_off", rsp_rdata, 64'h8000_0010);

        // Zero store to tohost: acknowledged, no pulse, stays idle.
        send(1'b1, 32'h0000_1000, 64'hFFFF_FFFF_0000_0000);
        check("zero_status", 64'(status()), 64'(4'b1010));
        check("zero_tohost", 64'(tohost), 64'd0);
        send(1'b0, 32'h0000_1000, 64'd0);
        check("zero_readback", rsp_rdata, 64'd0);

        // Store to an unrelated address is dropped.
        send(1'b1, 32'h0000_2000, 64'h1234_5678);
        check("other_store", 64'(status()), 64'(4'b1010));
        check("other_tohost", 64'(tohost), 64'd0);

        // Host reply collides with core clearing fromhost: host wins.
        fromhost_we = 1'b1;
        fromhost    = 32'hAA;
        send(1'b1, 32'h0000_1040, 64'd0);
        fromhost_we = 1'b0;
        fromhost    = '0;
        send(1'b0, 32'h0000_1040, 64'd0);
        check("collide_rdata", rsp_rdata, 64'hAA);

        // Reset asserted while waiting aborts immediately.
        send(1'b1, 32'h0000_1000, 64'h2);
        check("rst_notify", 64'(tohost_we), 64'd1);
        tick();
        check("rst_waiting", 64'(status()), 64'(4'b0000));
        #2;
        RSTn = 1'b0;
        #1;
        check("rst_async_status", 64'(status()), 64'(4'b1000));
        check("rst_async_tohost", 64'(tohost), 64'd0);
        tick();
        RSTn = 1'b1;
        tick();
        send(1'b0, 32'h0000_1008, 64'd0);
        check("rst_other_ld_v", 64'(rsp_valid), 64'd1);
        check("rst_other_ld_d", rsp_rdata, 64'd0);
        send(1'b0, 32'h0000_1040, 64'd0);
        check("rst_fromhost_clr", rsp_rdata, 64'd0);

        // Exit code 1: pulse, then permanent halt ignoring host and core.
        send(1'b1, 32'h0000_1000, 64'h1);
        check("exit_status", 64'(status()), 64'(4'b0110));
        check("exit_tohost", 64'(tohost), 64'h1);
        tick();
        check("halt_status", 64'(status()), 64'(4'b0001));
        fromhost_we = 1'b1;
        fromhost    = 32'h77;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_1040;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_frozen", 64'(status()), 64'(4'b0001));
            check("halt_tohost", 64'(tohost), 64'h1);
        end
        fromhost_we = 1'b0;
        req_valid   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
